// File: rtl/pmu_stream_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : pmu_stream_checker_if
// Purpose  : Bundles the serial bitstream, config-chain and status signals
//            exchanged between the JTAG TAP side and pmu_stream_checker.
// Modports : master - TAP / bench side (drives bitstream and readback in)
//            slave  - pmu_stream_checker side
// Signals  : en_i, data_i, checksum_en_i   bitstream strobe, bit, mode select
//            data_o, cfg_en_o              payload bit and valid to config chain
//            data_ccff_i, data_ccff_o      config chain readback path
//            flag_o_fpga, flag_o_jtag      fabric / TAP reset requests
//            done_o, pass_o                frame verification status
// Revision : 1.0 - initial release
// ============================================================================
interface pmu_stream_checker_if;
  logic en_i;
  logic data_i;
  logic checksum_en_i;
  logic data_o;
  logic cfg_en_o;
  logic data_ccff_i;
  logic data_ccff_o;
  logic flag_o_fpga;
  logic flag_o_jtag;
  logic done_o;
  logic pass_o;

  modport master (
    output en_i, data_i, checksum_en_i, data_ccff_i,
    input  data_o, cfg_en_o, data_ccff_o, flag_o_fpga, flag_o_jtag, done_o, pass_o
  );

  modport slave (
    input  en_i, data_i, checksum_en_i, data_ccff_i,
    output data_o, cfg_en_o, data_ccff_o, flag_o_fpga, flag_o_jtag, done_o, pass_o
  );
endinterface
`default_nettype wire

// File: rtl/pmu_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : pmu_stream_checker
// Purpose  : Bitstream protection unit between the JTAG TAP and the FPGA
//            configuration chain. Forwards payload bits to the chain and,
//            in checksum mode, verifies an 8-bit XOR trailer per frame. A
//            mismatch holds the fabric in reset and pulses a TAP reset.
// Ports    : tck_i   program clock, rising edge
//            rst_ni  asynchronous active-low reset
//            clr_i   synchronous clear (same effect as reset)
//            bus     pmu_stream_checker_if.slave (bitstream, chain, status)
// Config   : PMU_CHECKSUM_EN - when defined, checksum verification is built
//            in; when undefined every frame is a plain bypass and all status
//            flags are tied low.
// Revision : 1.0 - initial release
// ============================================================================
module pmu_stream_checker #(
  parameter int PAYLOAD_W = 56,  // multiple of 8
  parameter int CS_W      = 8    // trailer width, fixed at 8
) (
  input  wire logic           tck_i,
  input  wire logic           rst_ni,
  input  wire logic           clr_i,
  pmu_stream_checker_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BYPASS  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_TRAILER = 3'd3,
    ST_CHECK   = 3'd4,
    ST_PASS    = 3'd5,
    ST_FAIL    = 3'd6
  } state_e;

  state_e state_q, state_d;
  logic   data_q, data_d;
  logic   cfg_en_q, cfg_en_d;

`ifdef PMU_CHECKSUM_EN
  localparam int CNT_W = $clog2(PAYLOAD_W);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CS_W-1:0]  byte_q, byte_d;
  logic [CS_W-1:0]  acc_q, acc_d;
  logic [CS_W-1:0]  exp_q, exp_d;
  logic             flag_fpga_q, flag_fpga_d;
  logic             flag_jtag_q, flag_jtag_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             pay_bit;
  logic [CS_W-1:0]  byte_next;

  // LSB-first assembly: after 8 shifts the first received bit sits in bit 0.
  assign byte_next = {bus.data_i, byte_q[CS_W-1:1]};
`endif

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cfg_en_d = 1'b0;
`ifdef PMU_CHECKSUM_EN
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    acc_d       = acc_q;
    exp_d       = exp_q;
    flag_fpga_d = flag_fpga_q;
    flag_jtag_d = flag_jtag_q;
    done_d      = done_q;
    pass_d      = pass_q;
    pay_bit     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // The mode is decided once here and is thereafter encoded by the
        // state itself, so later checksum_en_i changes have no effect.
        if (bus.en_i) begin
`ifdef PMU_CHECKSUM_EN
          if (bus.checksum_en_i) begin
            state_d = ST_PAYLOAD;
            pay_bit = 1'b1;  // first bit is payload bit 0
          end else begin
            state_d  = ST_BYPASS;
            data_d   = bus.data_i;
            cfg_en_d = 1'b1;
          end
`else
          state_d  = ST_BYPASS;
          data_d   = bus.data_i;
          cfg_en_d = 1'b1;
`endif
        end
      end

      ST_BYPASS: begin
        if (bus.en_i) begin
          data_d   = bus.data_i;
          cfg_en_d = 1'b1;
        end
      end

`ifdef PMU_CHECKSUM_EN
      ST_PAYLOAD: pay_bit = bus.en_i;

      ST_TRAILER: begin
        data_d = 1'b0;  // trailer bits never reach the chain
        if (bus.en_i) begin
          exp_d = {bus.data_i, exp_q[CS_W-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q[2:0] == 3'd7) begin
            cnt_d   = '0;
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        done_d = 1'b1;
        if (acc_q == exp_q) begin
          pass_d  = 1'b1;
          state_d = ST_PASS;
        end else begin
          flag_fpga_d = 1'b1;
          flag_jtag_d = 1'b1;
          state_d     = ST_FAIL;
        end
      end

      // TAP reset request is a single-cycle pulse; fabric reset is held.
      ST_FAIL: flag_jtag_d = 1'b0;

      ST_PASS: ;
`endif

      default: ;
    endcase

`ifdef PMU_CHECKSUM_EN
    if (pay_bit) begin
      data_d   = bus.data_i;
      cfg_en_d = 1'b1;
      byte_d   = byte_next;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q[2:0] == 3'd7) begin
        acc_d = acc_q ^ byte_next;
      end
      if (cnt_q == CNT_W'(PAYLOAD_W - 1)) begin
        cnt_d   = '0;
        state_d = ST_TRAILER;
      end
    end
`endif
  end

  // clr_i is a synchronous copy of reset and overrides any accepted bit.
  always_ff @(posedge tck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      data_q   <= 1'b0;
      cfg_en_q <= 1'b0;
`ifdef PMU_CHECKSUM_EN
      cnt_q       <= '0;
      byte_q      <= '0;
      acc_q       <= '0;
      exp_q       <= '0;
      flag_fpga_q <= 1'b0;
      flag_jtag_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
`endif
    end else if (clr_i) begin
      state_q  <= ST_IDLE;
      data_q   <= 1'b0;
      cfg_en_q <= 1'b0;
`ifdef PMU_CHECKSUM_EN
      cnt_q       <= '0;
      byte_q      <= '0;
      acc_q       <= '0;
      exp_q       <= '0;
      flag_fpga_q <= 1'b0;
      flag_jtag_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cfg_en_q <= cfg_en_d;
`ifdef PMU_CHECKSUM_EN
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      acc_q       <= acc_d;
      exp_q       <= exp_d;
      flag_fpga_q <= flag_fpga_d;
      flag_jtag_q <= flag_jtag_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
`endif
    end
  end

  assign bus.data_o      = data_q;
  assign bus.cfg_en_o    = cfg_en_q;
  assign bus.data_ccff_o = bus.data_ccff_i;  // readback is a pure wire

`ifdef PMU_CHECKSUM_EN
  assign bus.flag_o_fpga = flag_fpga_q;
  assign bus.flag_o_jtag = flag_jtag_q;
  assign bus.done_o      = done_q;
  assign bus.pass_o      = pass_q;
`else
  assign bus.flag_o_fpga = 1'b0;
  assign bus.flag_o_jtag = 1'b0;
  assign bus.done_o      = 1'b0;
  assign bus.pass_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pmu_stream_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pmu_stream_checker
// Purpose  : Directed self-checking bench for pmu_stream_checker. Covers
//            reset, readback, bypass, and (with PMU_CHECKSUM_EN) checksum
//            pass/fail, gapped strobes and reset in the middle of a frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmu_stream_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Payload bytes 01,02,04,08,10,20,40 sent byte 0 first, LSB-first.
  // XOR of the bytes is 0x7F.
  localparam logic [55:0] PAY = 56'h40_20_10_08_04_02_01;

  pmu_stream_checker_if bus();

  pmu_stream_checker #(
    .PAYLOAD_W (56),
    .CS_W      (8)
  ) dut (
    .tck_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Present one strobe/bit, then return 1 ns after the sampling edge.
  task automatic drive_bit(input logic en, input logic d);
    bus.en_i   = en;
    bus.data_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    bus.en_i = 1'b0;
    clr      = 1'b1;
    @(posedge clk);
    #1;
    clr      = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    rst_n = 1'b0;
    clr   = 1'b0;
    bus.en_i = 1'b0;
    bus.data_i = 1'b0;
    bus.checksum_en_i = 1'b0;
    bus.data_ccff_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    outs = {bus.data_o, bus.cfg_en_o, bus.flag_o_fpga, bus.flag_o_jtag, bus.done_o, bus.pass_o};
    n_cmp++;
    if (outs !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, want 000000", outs);
    end
    for (int k = 0; k < 2; k++) begin
      bus.data_ccff_i = ~bus.data_ccff_i;
      #1;
      n_cmp++;
      if (bus.data_ccff_o !== bus.data_ccff_i) begin
        n_fail++;
        $display("FAIL reset_readback%0d: got %b, want %b", k, bus.data_ccff_o, bus.data_ccff_i);
      end
    end
    rst_n = 1'b1;
    drive_bit(1'b0, 1'b0);
    outs = {bus.data_o, bus.cfg_en_o, bus.flag_o_fpga, bus.flag_o_jtag, bus.done_o, bus.pass_o};
    n_cmp++;
    if (outs !== 6'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b, want 000000", outs);
    end
  endtask

  task automatic test_readback();
    logic [3:0] seq;
    seq = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      bus.data_ccff_i = seq[k];
      #1;
      n_cmp++;
      if (bus.data_ccff_o !== seq[k]) begin
        n_fail++;
        $display("FAIL readback%0d: got %b, want %b", k, bus.data_ccff_o, seq[k]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [63:0] pat;
    pat = 64'hA5A5_A5A5_A5A5_A5A5;
    do_clear();
    bus.checksum_en_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 10) bus.checksum_en_i = 1'b1;  // must be ignored mid-frame
      drive_bit(1'b1, pat[i]);
      n_cmp++;
      if (bus.data_o !== pat[i] || bus.cfg_en_o !== 1'b1 ||
          {bus.flag_o_fpga, bus.flag_o_jtag, bus.done_o} !== 3'b000) begin
        n_fail++;
        $display("FAIL bypass_bit%0d: data_o=%b cfg_en_o=%b flags/done=%b, want %b 1 000",
                 i, bus.data_o, bus.cfg_en_o,
                 {bus.flag_o_fpga, bus.flag_o_jtag, bus.done_o}, pat[i]);
      end
    end
    drive_bit(1'b0, 1'b0);
    n_cmp++;
    if (bus.cfg_en_o !== 1'b0 || bus.data_o !== pat[63]) begin
      n_fail++;
      $display("FAIL bypass_gap: cfg_en_o=%b data_o=%b, want 0 %b", bus.cfg_en_o, bus.data_o, pat[63]);
    end
    bus.checksum_en_i = 1'b0;
  endtask

`ifdef PMU_CHECKSUM_EN
  // Sends one checksum-mode frame (optionally with an idle cycle before every
  // bit), checking forwarding bit by bit. Returns just after the CHECK edge.
  task automatic run_frame(input logic [55:0] pay, input logic [7:0] tr,
                           input bit gaps, input string tag);
    logic prev;
    prev = 1'b0;  // frames here always start from a cleared unit
    bus.checksum_en_i = 1'b1;
    for (int i = 0; i < 56; i++) begin
      if (i == 20) bus.checksum_en_i = 1'b0;  // must be ignored mid-frame
      if (gaps) begin
        drive_bit(1'b0, ~pay[i]);
        n_cmp++;
        if (bus.cfg_en_o !== 1'b0 || bus.data_o !== prev) begin
          n_fail++;
          $display("FAIL %s_gap%0d: cfg_en_o=%b data_o=%b, want 0 %b",
                   tag, i, bus.cfg_en_o, bus.data_o, prev);
        end
      end
      drive_bit(1'b1, pay[i]);
      n_cmp++;
      if (bus.data_o !== pay[i] || bus.cfg_en_o !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_pay%0d: data_o=%b cfg_en_o=%b, want %b 1",
                 tag, i, bus.data_o, bus.cfg_en_o, pay[i]);
      end
      prev = pay[i];
    end
    for (int j = 0; j < 8; j++) begin
      if (gaps) drive_bit(1'b0, ~tr[j]);
      drive_bit(1'b1, tr[j]);
      n_cmp++;
      if (bus.cfg_en_o !== 1'b0 || bus.data_o !== 1'b0 || bus.done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_trl%0d: cfg_en_o=%b data_o=%b done_o=%b, want 0 0 0",
                 tag, j, bus.cfg_en_o, bus.data_o, bus.done_o);
      end
    end
    drive_bit(1'b0, 1'b0);  // CHECK cycle
    bus.checksum_en_i = 1'b0;
  endtask

  task automatic test_pass();
    logic [3:0] st;
    do_clear();
    run_frame(PAY, 8'h7F, 1'b0, "pass");
    st = {bus.done_o, bus.pass_o, bus.flag_o_fpga, bus.flag_o_jtag};
    n_cmp++;
    if (st !== 4'b1100) begin
      n_fail++;
      $display("FAIL pass_status: done/pass/fpga/jtag=%b, want 1100", st);
    end
    for (int k = 0; k < 3; k++) begin
      drive_bit(1'b1, 1'b1);
      st = {bus.done_o, bus.pass_o, bus.flag_o_fpga, bus.flag_o_jtag};
      n_cmp++;
      if (st !== 4'b1100 || bus.cfg_en_o !== 1'b0) begin
        n_fail++;
        $display("FAIL pass_hold%0d: status=%b cfg_en_o=%b, want 1100 0", k, st, bus.cfg_en_o);
      end
    end
  endtask

  task automatic test_fail();
    logic [3:0] st;
    do_clear();
    run_frame(PAY, 8'h7E, 1'b0, "fail");
    st = {bus.done_o, bus.pass_o, bus.flag_o_fpga, bus.flag_o_jtag};
    n_cmp++;
    if (st !== 4'b1011) begin
      n_fail++;
      $display("FAIL fail_status: done/pass/fpga/jtag=%b, want 1011", st);
    end
    drive_bit(1'b0, 1'b0);
    st = {bus.done_o, bus.pass_o, bus.flag_o_fpga, bus.flag_o_jtag};
    n_cmp++;
    if (st !== 4'b1010) begin
      n_fail++;
      $display("FAIL fail_jtag_pulse: done/pass/fpga/jtag=%b, want 1010", st);
    end
    for (int k = 0; k < 3; k++) begin
      drive_bit(1'b1, 1'b0);
      st = {bus.done_o, bus.pass_o, bus.flag_o_fpga, bus.flag_o_jtag};
      n_cmp++;
      if (st !== 4'b1010 || bus.cfg_en_o !== 1'b0) begin
        n_fail++;
        $display("FAIL fail_hold%0d: status=%b cfg_en_o=%b, want 1010 0", k, st, bus.cfg_en_o);
      end
    end
    // clr together with a valid bit: clear wins and the bit is dropped
    clr = 1'b1;
    drive_bit(1'b1, 1'b1);
    clr = 1'b0;
    bus.en_i = 1'b0;
    st = {bus.done_o, bus.pass_o, bus.flag_o_fpga, bus.flag_o_jtag};
    n_cmp++;
    if (st !== 4'b0000 || bus.cfg_en_o !== 1'b0 || bus.data_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fail_clr: status=%b cfg_en_o=%b data_o=%b, want 0000 0 0",
               st, bus.cfg_en_o, bus.data_o);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] st;
    do_clear();
    run_frame(PAY, 8'h7F, 1'b1, "gaps");
    st = {bus.done_o, bus.pass_o, bus.flag_o_fpga, bus.flag_o_jtag};
    n_cmp++;
    if (st !== 4'b1100) begin
      n_fail++;
      $display("FAIL gaps_status: done/pass/fpga/jtag=%b, want 1100", st);
    end
  endtask

  task automatic test_reset_midframe();
    logic [55:0] p;
    logic [3:0]  st;
    p = PAY;
    do_clear();
    bus.checksum_en_i = 1'b1;
    for (int i = 0; i < 30; i++) drive_bit(1'b1, p[i]);
    bus.en_i = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.data_o, bus.cfg_en_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_async: data_o/cfg_en_o=%b, want 00", {bus.data_o, bus.cfg_en_o});
    end
    bus.data_ccff_i = ~bus.data_ccff_i;
    #1;
    n_cmp++;
    if (bus.data_ccff_o !== bus.data_ccff_i) begin
      n_fail++;
      $display("FAIL rstmid_readback: got %b, want %b", bus.data_ccff_o, bus.data_ccff_i);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(56'h0, 8'h00, 1'b0, "rstmid");
    st = {bus.done_o, bus.pass_o, bus.flag_o_fpga, bus.flag_o_jtag};
    n_cmp++;
    if (st !== 4'b1100) begin
      n_fail++;
      $display("FAIL rstmid_status: done/pass/fpga/jtag=%b, want 1100", st);
    end
  endtask
`else
  // Without checksum support, a checksum-mode frame is just a bypass stream.
  task automatic test_no_checksum();
    logic [71:0] pat;
    pat = 72'hC3_0123_4567_89AB_CDEF;
    do_clear();
    bus.checksum_en_i = 1'b1;
    for (int i = 0; i < 72; i++) begin
      drive_bit(1'b1, pat[i]);
      n_cmp++;
      if (bus.data_o !== pat[i] || bus.cfg_en_o !== 1'b1 ||
          {bus.flag_o_fpga, bus.flag_o_jtag, bus.done_o, bus.pass_o} !== 4'b0000) begin
        n_fail++;
        $display("FAIL nocs_bit%0d: data_o=%b cfg_en_o=%b status=%b, want %b 1 0000",
                 i, bus.data_o, bus.cfg_en_o,
                 {bus.flag_o_fpga, bus.flag_o_jtag, bus.done_o, bus.pass_o}, pat[i]);
      end
    end
    bus.checksum_en_i = 1'b0;
    bus.en_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_readback();
    test_bypass();
`ifdef PMU_CHECKSUM_EN
    test_pass();
    test_fail();
    test_gaps();
    test_reset_midframe();
`else
    test_no_checksum();
`endif
    test_readback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
